// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources
module uart_tx_sched #(
  parameter int                 NUM_REQ      = 4,
  parameter logic [NUM_REQ-1:0] PARITY_MASK  = '0,
  parameter int                 GAP_CYCLES   = 0,
  parameter int                 BUSY_TIMEOUT = 16,
  localparam int                ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_parity_mode,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 frame_done,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, GAP} state_t;
  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]      ptr_q, ptr_d, grant_id_q, grant_id_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 parity_q, parity_d, tx_start_q, tx_start_d;
  logic                 frame_done_q, frame_done_d, timeout_err_q, timeout_err_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  int                   win;
  // winner scan: walk from farthest to nearest after ptr so the nearest valid index is kept
  always_comb begin
    win = 0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) win = (int'(ptr_q) + k) % NUM_REQ;
  end
  // next-state and output logic; pulses default low, held outputs keep their value
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    parity_d      = parity_q;
    tx_start_d    = 1'b0;
    req_ready_d   = '0;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: if (en && !tx_busy && |req_valid) begin
        state_d     = WAIT_HI;
        cnt_d       = '0;
        ptr_d       = ID_W'(win);
        grant_id_d  = ID_W'(win);
        tx_data_d   = req_data[8*win +: 8];
        parity_d    = PARITY_MASK[win];
        tx_start_d  = 1'b1;
        req_ready_d = NUM_REQ'(1) << win;
      end
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
        else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else cnt_d = cnt_q + 16'd1;
      WAIT_LO: if (!tx_busy) begin
        frame_done_d = 1'b1;
        state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
        cnt_d        = 16'(GAP_CYCLES);
      end
      GAP: begin
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q <= 16'd1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; ptr resets to the last index so requester 0 is scanned first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      parity_q      <= 1'b0;
      tx_start_q    <= 1'b0;
      req_ready_q   <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      parity_q      <= parity_d;
      tx_start_q    <= tx_start_d;
      req_ready_q   <= req_ready_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  assign req_ready      = req_ready_q;
  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign tx_parity_mode = parity_q;
  assign grant_id       = grant_id_q;
  assign frame_done     = frame_done_q;
  assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with a simple transmitter model
module tb_uart_tx_sched;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [8*N-1:0] req_data;
  logic tx_start, tx_parity_mode, tx_busy, frame_done, timeout_err;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  logic model_busy = 1'b0, ext_busy = 1'b0, dead = 1'b0, busy_prev = 1'b0;
  logic [N-1:0] pm = 4'b1010;
  int total = 0, bad = 0, cyc = 0, n_start = 0, fall_cyc = -100;
  int s, f, t, ns0;
  logic [7:0] bytes [N][4];
  int idx [N], cnt [N];
  typedef struct {int id; logic [7:0] d; logic p;} exp_t;
  exp_t exp_q [$];

  assign tx_busy = model_busy | ext_busy;

  uart_tx_sched #(.NUM_REQ(N), .PARITY_MASK(4'b1010), .GAP_CYCLES(5), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_parity_mode(tx_parity_mode), .tx_busy(tx_busy), .grant_id(grant_id),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = idx[i] < cnt[i];
      req_data[8*i +: 8] = (idx[i] < cnt[i]) ? bytes[i][idx[i]] : 8'h00;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (req_ready[i]) idx[i]++;
    refresh();
  endtask

  task automatic load(input int i, input logic [7:0] b);
    if (idx[i] == cnt[i]) begin
      idx[i] = 0;
      cnt[i] = 0;
    end
    bytes[i][cnt[i]] = b;
    cnt[i]++;
    refresh();
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    e.p  = pm[id];
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      tick();
      b++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (40) tick();
  endtask

  task automatic wait_start(output int c);
    int b = 0;
    do begin tick(); b++; end while (!tx_start && b < 200);
    chk("start_seen", tx_start, 1);
    c = cyc;
  endtask

  task automatic wait_fd(output int c);
    int b = 0;
    do begin tick(); b++; end while (!frame_done && b < 200);
    chk("frame_done_seen", frame_done, 1);
    c = cyc;
  endtask

  task automatic wait_err(output int c);
    int b = 0;
    do begin tick(); b++; end while (!timeout_err && b < 60);
    chk("timeout_seen", timeout_err, 1);
    c = cyc;
  endtask

  // transmitter: busy two clocks after a start, for 20 clocks, unless dead
  initial forever begin
    @(negedge clk);
    if (tx_start && !dead) begin
      repeat (2) @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (20) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  // monitor: scoreboard on every start, frame_done latency against busy falling
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy_prev && tx_busy === 1'b0) fall_cyc = cyc;
    busy_prev = tx_busy;
    if (tx_start) begin
      n_start++;
      chk("start_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_id", grant_id, e.id);
        chk("tx_data", tx_data, e.d);
        chk("parity", tx_parity_mode, e.p);
        chk("req_ready", req_ready, 1 << e.id);
      end
    end else if (req_ready != 0) chk("stray_ready", req_ready, 0);
    if (frame_done) chk("frame_done_lat", cyc - fall_cyc, 1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      idx[i] = 0;
      cnt[i] = 0;
    end
    refresh();
    #1;
    chk("rst_start", tx_start, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_parity", tx_parity_mode, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", timeout_err, 0);
    repeat (3) tick();
    rst = 1'b0;
    en  = 1'b1;
    // round robin with all four valid, requester 0 holding a second byte
    load(0, 8'h11); load(0, 8'h55); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h55);
    drain();
    // valid=0101 from ptr=0
    load(0, 8'h88); load(2, 8'h66); load(2, 8'h77);
    push(2, 8'h66); push(0, 8'h88); push(2, 8'h77);
    drain();
    // single requester, one-clock latency
    push(0, 8'hA5);
    load(0, 8'hA5);
    @(posedge clk);
    #1;
    chk("lat_start", tx_start, 1);
    chk("lat_ready", req_ready, 4'b0001);
    drain();
    // inter-frame gap of 5
    load(1, 8'h12); load(3, 8'h34);
    push(1, 8'h12); push(3, 8'h34);
    wait_fd(f);
    wait_start(s);
    chk("gap_cycles", s - f, 6);
    drain();
    // busy timeout
    dead = 1'b1;
    push(2, 8'h5A);
    load(2, 8'h5A);
    wait_start(s);
    wait_err(t);
    chk("timeout_lat", t - s, 16);
    dead = 1'b0;
    repeat (5) tick();
    chk("err_sticky", timeout_err, 1);
    push(1, 8'h77);
    load(1, 8'h77);
    drain();
    chk("err_sticky2", timeout_err, 1);
    // enable and external busy gating
    ns0 = n_start;
    en = 1'b0;
    load(1, 8'h99);
    repeat (10) tick();
    chk("en0_nostart", n_start, ns0);
    ext_busy = 1'b1;
    push(1, 8'h99);
    en = 1'b1;
    repeat (10) tick();
    chk("busy_block", n_start, ns0);
    ext_busy = 1'b0;
    wait_start(s);
    en = 1'b0;
    load(3, 8'hAB);
    wait_fd(f);
    repeat (20) tick();
    chk("en_mid_frame", n_start, ns0 + 1);
    // reset while waiting for busy to fall
    push(3, 8'hAB);
    en = 1'b1;
    wait_start(s);
    repeat (6) tick();
    chk("in_wait_lo_busy", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_gid", grant_id, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_parity", tx_parity_mode, 0);
    chk("arst_err", timeout_err, 0);
    chk("arst_start", {tx_start, frame_done, req_ready}, 0);
    tick();
    rst = 1'b0;
    load(0, 8'hC3); load(3, 8'hDD);
    push(0, 8'hC3); push(3, 8'hDD);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources.
- Accepts bytes from requesters with a valid/ready handshake and issues one-cycle tx_start pulses with data and parity mode.
- Tracks transmitter tx_busy to sequence frames, inserts a programmable inter-frame gap, and flags a transmitter that never goes busy.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ) derived locally.
- PARITY_MASK, 0 (NUM_REQ bits), bit i = parity_mode driven for requester i's frames (1 = odd, 0 = even).
- GAP_CYCLES, 0, idle clocks forced between tx_busy falling and the next grant; 16-bit counter.
- BUSY_TIMEOUT, 16, clocks to wait for tx_busy to rise after tx_start before aborting; 16-bit counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  1 = grants allowed; 0 = no new grants, an in-flight frame completes.
- req_valid  in  NUM_REQ  per-requester byte pending; held with data until req_ready.
- req_data  in  8*NUM_REQ  requester i byte at [8*i+7:8*i].
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  8  byte to transmitter; held until next grant.
- tx_parity_mode  out  1  parity mode to transmitter; held until next grant.
- tx_busy  in  1  transmitter busy flag.
- grant_id  out  ID_W  index of last granted requester.
- frame_done  out  1  one-cycle pulse when tx_busy falls for the granted frame.
- timeout_err  out  1  sticky; set on busy timeout, cleared only by rst.

Behaviour:
- Reset (async on rst high): state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; gap and timeout counters 0.
- States: IDLE, WAIT_HI, WAIT_LO, GAP.
- IDLE:
  - Grant condition: en=1, tx_busy=0, and any req_valid.
  - Winner is the first valid index scanning (ptr+1) mod NUM_REQ upward with wrap.
  - On the granting edge: capture req_data[winner] into tx_data and PARITY_MASK[winner] into tx_parity_mode; set grant_id = winner, ptr = winner; assert tx_start=1 and req_ready[winner]=1 for exactly the next cycle; go to WAIT_HI with the timeout counter cleared.
  - Latency: valid seen in an idle cycle -> tx_start and req_ready high 1 clock later.
  - tx_busy=1 in IDLE, e.g. from an external user, blocks grants.
- WAIT_HI:
  - tx_start and req_ready return to 0.
  - tx_busy=1 -> WAIT_LO.
  - Otherwise increment the timeout counter; at BUSY_TIMEOUT-1 set timeout_err and go to IDLE with no frame_done. The byte counts as consumed.
- WAIT_LO: tx_busy=0 -> pulse frame_done for 1 cycle. Then load gap = GAP_CYCLES and go to GAP, or go directly to IDLE if GAP_CYCLES=0.
- GAP: decrement the counter each clock; at 1 -> IDLE. The total gap is exactly GAP_CYCLES clocks between frame_done and the first IDLE cycle.
- Fairness: a requester holding valid continuously cannot win twice while another valid requester is waiting.
- en falling mid-frame has no effect until IDLE. Valid dropped before ready: the requester is simply not considered; no partial accept.
- req_valid/req_data changes outside IDLE are ignored. req_ready is never asserted to a requester whose valid was low at the granting edge.
- rst mid-frame: immediate return to the reset values. The transmitter is not aborted; the next grant waits for tx_busy=0.

Test Plan:
- Single requester: NUM_REQ=4, req_valid=0001, data=8'hA5, transmitter model busy 2 clocks after start for 20 clocks -> tx_start and req_ready[0] high 1 clk after valid; tx_data=A5; parity_mode=PARITY_MASK[0]; frame_done 1 clk after busy falls; grant_id=0.
- Round robin: req_valid=1111 held, distinct data 11/22/33/44 -> grant order 0,1,2,3,0. Then valid=0101 from ptr=0 -> order 2,0,2.
- Gap: GAP_CYCLES=5, two queued requests -> exactly 5 idle clocks between frame_done and the second tx_start.
- Timeout: BUSY_TIMEOUT=16, transmitter never raises busy -> timeout_err set 16 clocks after WAIT_HI entry and stays set; the next request is granted normally.
- Enable/busy gating: en=0 with valid=0010 -> no tx_start. External tx_busy=1 with en=1 -> no grant until busy drops; en deasserted mid-frame -> frame completes, no further grant.
- Reset mid-frame: rst pulsed in WAIT_LO -> all outputs 0 asynchronously; after release, requester 0 wins first when valid=1001.
